instr_fetcher: RTL and testbench

Front-end stage ahead of the Decoder. Holds the PC and issues one word fetch at a time to the icache. Buffers returned instructions with their addresses in a circular instruction queue, and presents the queue head to the Decoder as instr_valid / instr_out / instr_addr_out. A pipeline flush from the RoB empties the queue, redirects the PC and discards any in-flight response.

---
 rtl/instr_fetcher.sv | 82 ++++++++
 tb/tb_instr_fetcher.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetcher.sv
// instr_fetcher: PC + one-outstanding icache fetch + circular instruction queue; JAL redirect under FETCH_JAL_PREDICT_EN
module instr_fetcher #(
  parameter int          QUEUE_WIDTH = 3,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        instr_issued,
  input  logic        flush,
  input  logic [31:0] flush_pc
);
  localparam int DEPTH = 1 << QUEUE_WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_DISCARD = 2'd2;
  logic [1:0]             r_state;
  logic [31:0]            r_pc;
  logic [QUEUE_WIDTH-1:0] r_head, r_tail;
  logic [QUEUE_WIDTH:0]   r_count;
  logic [31:0]            r_q_data [DEPTH];
  logic [31:0]            r_q_addr [DEPTH];
  logic                   w_push, w_pop, w_full;
  logic [31:0]            w_next_pc;
  assign w_full      = r_count[QUEUE_WIDTH];
  assign w_push      = !flush && r_state == S_WAIT && ic_resp_valid;
  assign w_pop       = !flush && instr_issued && r_count != '0;
  assign instr_valid = r_count != '0;
  assign instr_out      = instr_valid ? r_q_data[r_head] : '0;
  assign instr_addr_out = instr_valid ? r_q_addr[r_head] : '0;
`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] w_jal_tgt;
  assign w_jal_tgt = r_pc + {{11{ic_resp_data[31]}}, ic_resp_data[31], ic_resp_data[19:12],
                             ic_resp_data[20], ic_resp_data[30:21], 1'b0};
  assign w_next_pc = ic_resp_data[6:0] == 7'b1101111 ? w_jal_tgt : r_pc + 32'd4;
`else
  assign w_next_pc = r_pc + 32'd4;
`endif
  // queue storage: written at tail on every accepted response
  always_ff @(posedge clk)
    if (rdy && w_push) begin
      r_q_data[r_tail] <= ic_resp_data;
      r_q_addr[r_tail] <= r_pc;
    end
  // fetch FSM, pc and queue pointers; flush dominates everything
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      ic_req_valid <= 1'b0;
      ic_req_addr  <= '0;
    end else if (rdy) begin
      ic_req_valid <= 1'b0;
      if (flush) begin
        r_pc    <= flush_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_state <= (r_state == S_IDLE || (r_state == S_WAIT && ic_resp_valid)) ? S_IDLE : S_DISCARD;
      end else begin
        if (w_pop) r_head <= r_head + QUEUE_WIDTH'(1);
        if (w_push) begin
          r_tail <= r_tail + QUEUE_WIDTH'(1);
          r_pc   <= w_next_pc;
        end
        r_count <= r_count + {{QUEUE_WIDTH{1'b0}}, w_push} - {{QUEUE_WIDTH{1'b0}}, w_pop};
        if (r_state == S_IDLE && !w_full) begin
          ic_req_valid <= 1'b1;
          ic_req_addr  <= r_pc;
          r_state      <= S_WAIT;
        end else if (r_state != S_IDLE && ic_resp_valid) r_state <= S_IDLE;
      end
    end
endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: scoreboard bench for instr_fetcher with a behavioural icache
module tb_instr_fetcher;
  logic        clk = 0, rst = 1, rdy = 1;
  logic        ic_req_valid, ic_resp_valid = 0, instr_valid, instr_issued = 0, flush = 0;
  logic [31:0] ic_req_addr, ic_resp_data = 0, instr_out, instr_addr_out, flush_pc = 0;
  int          checks = 0, fails = 0, reqs = 0, served = 0;
  logic [31:0] exp_pc = 0;
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  instr_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_addr_out(instr_addr_out),
    .instr_issued(instr_issued), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] d);
    logic [20:0] imm;
    imm = {d[31], d[19:12], d[20], d[30:21], 1'b0};
`ifdef FETCH_JAL_PREDICT_EN
    if (d[6:0] == 7'h6f) return pc + {{11{imm[20]}}, imm};
`endif
    return pc + 4;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // every request address must match the model pc
  always @(negedge clk)
    if (ic_req_valid && rdy && !rst) begin
      check("req_addr", ic_req_addr, exp_pc);
      reqs++;
    end

  task automatic pop_chk();
    if (q_addr.size() == 0) begin
      check("pop_sb_empty", 32'd0, 32'd1);
      return;
    end
    check("pop_valid", 32'(instr_valid), 32'd1);
    check("pop_addr", instr_addr_out, q_addr.pop_front());
    check("pop_data", instr_out, q_data.pop_front());
    instr_issued = 1;
    cyc();
    instr_issued = 0;
  endtask

  // icache: answer the outstanding request; optionally pop at the push edge or stall with rdy=0
  task automatic fetch(input logic [31:0] d, input bit pop, input bit stall);
    int n = 0;
    logic [31:0] snap;
    while (reqs == served && n < 50) begin
      cyc();
      n++;
    end
    if (reqs == served) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    cyc();
    ic_resp_data = d;
    if (stall) begin
      snap = instr_addr_out;
      rdy = 0;
      ic_resp_valid = 1;
      instr_issued = 1;
      repeat (5) begin
        cyc();
        check("stall_head", instr_addr_out, snap);
        check("stall_req", 32'(ic_req_valid), 32'd0);
      end
      instr_issued = 0;
      rdy = 1;
    end
    if (pop) begin
      check("pp_addr", instr_addr_out, q_addr.pop_front());
      check("pp_data", instr_out, q_data.pop_front());
      instr_issued = 1;
    end
    ic_resp_valid = 1;
    cyc();
    ic_resp_valid = 0;
    instr_issued = 0;
    served++;
    q_addr.push_back(exp_pc);
    q_data.push_back(d);
    exp_pc = next_pc(exp_pc, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_out", instr_out, 32'd0);
    check("rst_addr", instr_addr_out, 32'd0);
    check("rst_req", 32'(ic_req_valid), 32'd0);
    check("rst_req_addr", ic_req_addr, 32'd0);
    cyc();
    rst = 0;
    // 1: fill the queue
    for (int i = 0; i < 8; i++) fetch({i[11:0], 20'h00013}, 0, 0);
    repeat (8) cyc();
    check("full_no_req", 32'(reqs - served), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_head", instr_addr_out, 32'h0);
    // 2: one pop refills with wrapped tail
    pop_chk();
    check("after_pop_head", instr_addr_out, 32'h4);
    fetch(32'hA0000013, 0, 0);
    repeat (8) cyc();
    check("refill_one_req", 32'(reqs - served), 32'd0);
    for (int i = 0; i < 8; i++) pop_chk();
    // 3: flush while waiting
    repeat (3) cyc();
    check("pend_before_flush", 32'(reqs - served), 32'd1);
    flush = 1;
    flush_pc = 32'h100;
    cyc();
    flush = 0;
    q_addr.delete();
    q_data.delete();
    exp_pc = 32'h100;
    check("flush_valid", 32'(instr_valid), 32'd0);
    instr_issued = 1;
    cyc();
    instr_issued = 0;
    ic_resp_data = 32'hDEAD0013;
    ic_resp_valid = 1;
    cyc();
    ic_resp_valid = 0;
    served++;
    check("drop_valid", 32'(instr_valid), 32'd0);
    fetch(32'hB0000013, 0, 0);
    check("flush_entry", instr_addr_out, 32'h100);
    // 4: push and pop together at count=1
    fetch(32'hC0000013, 1, 0);
    check("pp_valid", 32'(instr_valid), 32'd1);
    pop_chk();
    check("pp_empty", 32'(instr_valid), 32'd0);
    // 5: rdy stall during WAIT
    fetch(32'hD0000013, 0, 0);
    fetch(32'hE0000013, 0, 1);
    pop_chk();
    pop_chk();
    // 6: JAL prediction (forward, backward) from reset
    rst = 1;
    #1;
    check("rst2_valid", 32'(instr_valid), 32'd0);
    check("rst2_req_addr", ic_req_addr, 32'd0);
    cyc();
    q_addr.delete();
    q_data.delete();
    exp_pc = 0;
    reqs = 0;
    served = 0;
    rst = 0;
    fetch(32'h1000006F, 0, 0);
    fetch(32'hFF9FF06F, 0, 0);
    fetch(32'h00000013, 0, 0);
    for (int i = 0; i < 3; i++) pop_chk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
